// File: rtl/conv3x3_pkg.sv
// Shared constants and window-slice indexing for the 3x3 convolution datapath.
// Row 0 / column 0 (top-left) tap occupies the most significant slice.
package conv3x3_pkg;

    localparam int KSIZE  = 3;
    localparam int NTAPS  = KSIZE * KSIZE;
    localparam int DATA_W = 8;

    function automatic int tap(input int i, input int j, input int dw = DATA_W);
        return (NTAPS - 1 - (i * KSIZE + j)) * dw;
    endfunction

endpackage

// File: rtl/conv3x3_line_buffer.sv
// Single-row pixel store: combinational read and synchronous write at the same
// address, so a read in the write cycle returns the previous row's value.
module conv3x3_line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Storage is deliberately not reset; emission gating hides stale rows.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Turns a raster-order pixel stream into registered 3x3 windows with a
// one-entry valid/ready output stage and frame start/end qualifiers.
module conv3x3_window_gen
    import conv3x3_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  pix_valid,
    input  logic [DATA_W-1:0]     pix_in,
    output logic                  pix_ready,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [9*DATA_W-1:0]   win_out,
    output logic                  first_win,
    output logic                  frame_done
);

    localparam int WIN_W = NTAPS * DATA_W;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]       col_q, col_d, pos_c;
    logic [RW-1:0]       row_q, row_d, pos_r;
    logic [WIN_W-1:0]    sh_q, sh_d;
    logic [WIN_W-1:0]    win_out_q, win_out_d;
    logic                win_valid_q, win_valid_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                accept, emit;
    logic [2*DATA_W-1:0] lb_rd, lb_wr;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;

    // sof forces the accepted pixel to (0,0) without waiting a cycle.
    assign pos_c = sof ? '0 : col_q;
    assign pos_r = sof ? '0 : row_q;

    assign emit = accept && (pos_r >= ROW_TWO) && (pos_c >= COL_TWO);

    // Both line buffers share one array: upper half is two rows back.
    assign lb_wr = {lb_rd[DATA_W-1:0], pix_in};

    conv3x3_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (2 * DATA_W)
    ) u_linebuf (
        .clk_i   (clk),
        .en_i    (accept),
        .addr_i  (pos_c),
        .wdata_i (lb_wr),
        .rdata_o (lb_rd)
    );

    always_comb begin
        sh_d = sh_q;
        if (accept) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    sh_d[tap(i, j, DATA_W) +: DATA_W] = sh_q[tap(i, j + 1, DATA_W) +: DATA_W];
                end
            end
            sh_d[tap(0, 2, DATA_W) +: DATA_W] = lb_rd[2*DATA_W-1 -: DATA_W];
            sh_d[tap(1, 2, DATA_W) +: DATA_W] = lb_rd[DATA_W-1:0];
            sh_d[tap(2, 2, DATA_W) +: DATA_W] = pix_in;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pos_c == COL_LAST) begin
                col_d = '0;
                row_d = (pos_r == ROW_LAST) ? '0 : pos_r + 1'b1;
            end else begin
                col_d = pos_c + 1'b1;
                row_d = pos_r;
            end
        end
    end

    // A load can coincide with a consume; the new window simply replaces it.
    always_comb begin
        win_out_d   = win_out_q;
        win_valid_d = win_valid_q;
        first_d     = first_q;
        last_d      = last_q;
        done_d      = win_valid_q && win_ready && last_q;
        if (emit) begin
            win_out_d   = sh_d;
            win_valid_d = 1'b1;
            first_d     = (pos_r == ROW_TWO) && (pos_c == COL_TWO);
            last_d      = (pos_r == ROW_LAST) && (pos_c == COL_LAST);
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            first_d     = 1'b0;
            last_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            sh_q        <= '0;
            win_out_q   <= '0;
            win_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sh_q        <= sh_d;
            win_out_q   <= win_out_d;
            win_valid_q <= win_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign win_out    = win_out_q;
    assign win_valid  = win_valid_q;
    assign first_win  = first_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Randomized bench for conv3x3_window_gen on a 5x5 image, checked against an
// image-array reference that builds each expected window directly from pixels.
module tb_conv3x3_window_gen;
    import conv3x3_pkg::*;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int WW = NTAPS * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_ready;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic [WW-1:0] win_out;
    logic          first_win;
    logic          frame_done;

    conv3x3_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_out    (win_out),
        .first_win  (first_win),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rmode = 0;
    int done_cnt = 0;
    int viol = 0;

    logic [WW-1:0] exp_win[$];
    logic [WW-1:0] got_win[$];
    bit            exp_first[$];
    bit            got_first[$];
    logic [DW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;

    always @(posedge clk) begin
        #1;
        if (rmode == 1) win_ready = ~win_ready;
        else if (rmode == 2) win_ready = 1'($urandom_range(0, 1));
        else win_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid && win_ready) begin
                got_win.push_back(win_out);
                got_first.push_back(first_win);
            end
            if (frame_done) done_cnt++;
            if (pix_ready !== (!win_valid || win_ready)) viol++;
        end
    end

    function automatic void model_pix(input logic [DW-1:0] v, input bit s);
        logic [WW-1:0] w;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            w = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[(8 - (i * 3 + j)) * DW +: DW] = img[mr - 2 + i][mc - 2 + j];
            exp_win.push_back(w);
            exp_first.push_back(mr == 2 && mc == 2);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endfunction

    task automatic send_pix(input logic [DW-1:0] v, input bit s, input int gap);
        bit acc;
        int n;
        pix_valid = 1'b0;
        sof = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_in = v;
        sof = s;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout got pix_ready=0 required 1 within 100 cycles");
        end else begin
            model_pix(v, s);
        end
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit s, input int maxgap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(DW'(((r << 4) | c) + base), s && r == 0 && c == 0,
                         int'($urandom_range(0, maxgap)));
    endtask

    task automatic drain();
        int n = 0;
        while (got_win.size() < exp_win.size() && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        exp_win.delete();
        got_win.delete();
        exp_first.delete();
        got_first.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b required 0", win_valid); end
        checks++; if (win_out !== '0) begin errors++; $display("FAIL reset_win_out got %h required 0", win_out); end
        checks++; if (first_win !== 1'b0) begin errors++; $display("FAIL reset_first_win got %b required 0", first_win); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b required 0", frame_done); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready got %b required 1", pix_ready); end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_basic();
        rmode = 0;
        clear_sb();
        send_frame(0, 1'b1, 0);
        drain();
        checks++; if (got_win.size() !== 9) begin errors++; $display("FAIL basic_count got %0d required 9", got_win.size()); end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_first[k] !== exp_first[k]) begin
                errors++;
                $display("FAIL basic_win%0d got %h first=%0d required %h first=%0d", k, got_win[k], got_first[k], exp_win[k], exp_first[k]);
            end
        end
        if (got_win.size() == 9) begin
            checks++; if (got_win[0] !== 72'h000102101112202122 || got_first[0] !== 1'b1) begin errors++; $display("FAIL basic_first got %h/%0d required 000102101112202122/1", got_win[0], got_first[0]); end
            checks++; if (got_win[8] !== 72'h222324323334424344) begin errors++; $display("FAIL basic_last got %h required 222324323334424344", got_win[8]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_frame_done got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_ready_toggle();
        rmode = 1;
        clear_sb();
        send_frame(0, 1'b1, 1);
        drain();
        rmode = 0;
        checks++; if (got_win.size() !== 9) begin errors++; $display("FAIL toggle_count got %0d required 9", got_win.size()); end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_first[k] !== exp_first[k]) begin
                errors++;
                $display("FAIL toggle_win%0d got %h first=%0d required %h first=%0d", k, got_win[k], got_first[k], exp_win[k], exp_first[k]);
            end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL toggle_pix_ready got %0d bad cycles required 0", viol); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL toggle_frame_done got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        rmode = 0;
        clear_sb();
        send_frame(0, 1'b1, 0);
        send_frame('h80, 1'b0, 0);
        drain();
        checks++; if (got_win.size() !== 18) begin errors++; $display("FAIL b2b_count got %0d required 18", got_win.size()); end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_first[k] !== exp_first[k]) begin
                errors++;
                $display("FAIL b2b_win%0d got %h first=%0d required %h first=%0d", k, got_win[k], got_first[k], exp_win[k], exp_first[k]);
            end
        end
        if (got_win.size() > 9) begin
            checks++; if (got_win[9] !== 72'h808182909192A0A1A2 || got_first[9] !== 1'b1) begin errors++; $display("FAIL b2b_second_first got %h/%0d required 808182909192a0a1a2/1", got_win[9], got_first[9]); end
        end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_frame_done got %0d pulses required 2", done_cnt); end
    endtask

    task automatic test_sof_restart();
        rmode = 0;
        clear_sb();
        for (int p = 0; p < 16; p++)
            send_pix(DW'(((p / W) << 4) | (p % W)), p == 0, 0);
        send_frame('h40, 1'b1, 0);
        drain();
        checks++; if (got_win.size() !== 12) begin errors++; $display("FAIL sof_count got %0d required 12", got_win.size()); end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_first[k] !== exp_first[k]) begin
                errors++;
                $display("FAIL sof_win%0d got %h first=%0d required %h first=%0d", k, got_win[k], got_first[k], exp_win[k], exp_first[k]);
            end
        end
        if (got_win.size() > 3) begin
            checks++; if (got_win[3] !== 72'h404142505152606162 || got_first[3] !== 1'b1) begin errors++; $display("FAIL sof_new_first got %h/%0d required 404142505152606162/1", got_win[3], got_first[3]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sof_frame_done got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        rmode = 0;
        clear_sb();
        for (int p = 0; p < 2 * W + 4; p++)
            send_pix(DW'(((p / W) << 4) | (p % W)), p == 0, 0);
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b required 1", win_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rstmid_win_valid got %b required 0", win_valid); end
        checks++; if (win_out !== '0) begin errors++; $display("FAIL rstmid_win_out got %h required 0", win_out); end
        checks++; if (first_win !== 1'b0) begin errors++; $display("FAIL rstmid_first_win got %b required 0", first_win); end
        #4 rst = 1'b0;
        mr = 0;
        mc = 0;
        clear_sb();
        @(posedge clk);
        #1;
        send_frame(0, 1'b0, 0);
        drain();
        checks++; if (got_win.size() !== 9) begin errors++; $display("FAIL rstmid_count got %0d required 9", got_win.size()); end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_first[k] !== exp_first[k]) begin
                errors++;
                $display("FAIL rstmid_win%0d got %h first=%0d required %h first=%0d", k, got_win[k], got_first[k], exp_win[k], exp_first[k]);
            end
        end
        if (got_win.size() > 0) begin
            checks++; if (got_win[0] !== 72'h000102101112202122) begin errors++; $display("FAIL rstmid_first got %h required 000102101112202122", got_win[0]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_frame_done got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_random();
        rmode = 2;
        clear_sb();
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < W * H; p++)
                send_pix(DW'($urandom), p == 0 && (f == 0 || $urandom_range(0, 1) == 1),
                         int'($urandom_range(0, 2)));
        drain();
        rmode = 0;
        checks++; if (got_win.size() !== 27) begin errors++; $display("FAIL rand_count got %0d required 27", got_win.size()); end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_first[k] !== exp_first[k]) begin
                errors++;
                $display("FAIL rand_win%0d got %h first=%0d required %h first=%0d", k, got_win[k], got_first[k], exp_win[k], exp_first[k]);
            end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rand_pix_ready got %0d bad cycles required 0", viol); end
        checks++; if (done_cnt !== 3) begin errors++; $display("FAIL rand_frame_done got %0d pulses required 3", done_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish required finish within 500us");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_frame_basic();
        test_ready_toggle();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
- Upstream feeder for the 3x3 convolution top: turns a raster-order pixel stream into 72-bit 3x3 windows.
- Each window drives `ifmap_in`. The `first_win` flag drives the `state` input (1 on the first window of a frame, 0 otherwise).
- Holds two line buffers plus a 3x3 shift window. The output is a one-entry registered stage with valid/ready handshake.

Parameters:
- IMG_W, 8, pixels per row (>=3)
- IMG_H, 8, rows per frame (>=3)
- DATA_W, 8, bits per pixel; window width is 9*DATA_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- sof  in  1  start of frame, sampled only with an accepted pixel; that pixel becomes (row 0, col 0)
- pix_valid  in  1  pixel present
- pix_in  in  DATA_W  pixel value
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- win_valid  out  1  window register holds valid data
- win_ready  in  1  downstream consumes window when win_valid && win_ready
- win_out  out  9*DATA_W  3x3 window
- first_win  out  1  qualifies win_out as the first window of the frame
- frame_done  out  1  one-cycle pulse when the last window of a frame is consumed

Behaviour:
- Reset (async, rst=1): win_valid=0, win_out=0, first_win=0, frame_done=0, col/row counters=0, window regs=0. Line-buffer storage is not reset.
- pix_ready = !win_valid || win_ready (combinational). The block stalls entirely while the output is held.
- On an accepted pixel (r,c):
  - Shift the window left one column; the new right column is {linebuf2[c], linebuf1[c], pix_in}.
  - Write linebuf2[c] <= linebuf1[c] and linebuf1[c] <= pix_in.
  - Advance col; when col wraps from IMG_W-1 to 0, advance row.
- Window emit: when the accepted pixel has r>=2 and c>=2, next cycle win_valid=1 and win_out holds the window ending at (r,c). Latency is 1 cycle from acceptance.
- Packing: win_out[9*DATA_W-1 -: DATA_W] = (r-2,c-2), then (r-2,c-1), (r-2,c), (r-1,c-2) … (r,c) at [DATA_W-1:0]. Top-left is the MSB; row-major order.
- first_win=1 with the window ending at (2,2); 0 for all other windows. It is valid only while win_valid.
- Windows per frame = (IMG_H-2)*(IMG_W-2). No window crosses a row boundary, because c<2 suppresses emission.
- win_valid clears when consumed and no new window is loaded in the same cycle. Simultaneous consume and load: the new window replaces the old, and win_valid stays 1.
- Frame end: accepting (IMG_H-1, IMG_W-1) wraps both counters to 0. frame_done pulses the cycle after that last window is consumed.
- sof with an accepted pixel: counters are forced so that pixel is (0,0), aborting any partial frame. Window regs are not cleared; emission gating handles this. A pending output window is still delivered.
- Pixels accepted after frame end without sof continue as the next frame (auto-wrap).
- rst asserted mid-frame: all state is cleared immediately. The next frame needs no sof.
- Counters: col width clog2(IMG_W), row width clog2(IMG_H). No arithmetic on pixel data.

Decomposition:
- Package conv3x3_pkg:
  - KSIZE=3, NTAPS=9, DATA_W default.
  - Window-slice index function tap(i,j) returning the bit offset of row i, column j.
  - Shared by this block, top, and the bench.
- Sub-module conv3x3_line_buffer: depth IMG_W, width DATA_W, read-before-write at an address with an enable. It is instantiated twice (linebuf1, linebuf2), or once at width 2*DATA_W.

Test Plan:
- IMG_W=IMG_H=5, pixel=(r<<4)|c, win_ready=1 -> first window 72'h000102101112202122 with first_win=1. Exactly 9 windows, the last 72'h222324323334424344. frame_done is one pulse.
- Same frame with win_ready toggling 1/0 every cycle -> identical 9 windows in order. pix_ready=0 whenever win_valid && !win_ready, and no pixel is lost or duplicated.
- Two back-to-back frames (second with pixel+0x80, no sof) -> second frame's first window is 72'h808182909192A0A1A2 with first_win=1. 18 windows total.
- sof reasserted at frame-1 pixel (3,1) -> restart. The next window appears only after new (2,2), with first_win=1 and value from the new pixels.
- rst pulsed asynchronously mid-cycle at pixel (2,3) -> win_valid, win_out and first_win are 0 immediately. The following clean frame produces the same 9 windows as test 1.
- Stream the 5x5 frame into conv3x3_window_gen -> top with filter_in=72'h010000000100000001 -> psumOut = tl+center+br per window. The first window gives 0x00+0x11+0x22 = 51.
